// File: rtl/piezo_scheduler_if.sv
// Tone-source request bus between the clock's tone sources and the piezo scheduler.
// master: tone sources / bench; slave: the scheduler.
interface piezo_scheduler_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_tone;
  logic              mute;
  logic [NREQ-1:0]   grant;
  logic [1:0]        owner;
  logic              busy;
  logic [7:0]        tone_out;
  logic              preempted;

  modport master (
    output req, req_tone, mute,
    input  grant, owner, busy, tone_out, preempted
  );

  modport slave (
    input  req, req_tone, mute,
    output grant, owner, busy, tone_out, preempted
  );
endinterface

// File: rtl/piezo_scheduler.sv
// Fixed-priority piezo arbiter with minimum hold before preemption and a silent gap.
// Optional grant-length limit with per-requester lockout under PIEZO_SCHED_TIMEOUT_EN.
module piezo_scheduler #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned MIN_HOLD  = 50,
  parameter int unsigned GAP       = 10,
  parameter int unsigned MAX_GRANT = 8000
) (
  input logic              clock,
  input logic              reset,
  piezo_scheduler_if.slave bus
);

  if (NREQ < 2 || NREQ > 4 || MAX_GRANT < 1) begin : g_bad_param
    $error("piezo_scheduler: NREQ must be 2..4 and MAX_GRANT >= 1");
  end

  typedef enum logic [1:0] {StIdle = 2'd0, StGrant = 2'd1, StGap = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      tone_q, tone_d;
  logic            preempted_q, preempted_d;
  logic [15:0]     hold_cnt_q, hold_cnt_d;
  logic [15:0]     gap_cnt_q, gap_cnt_d;

  logic [1:0]      owner_idx;
  logic [7:0]      owner_tone;
  logic            owner_req;
  logic            higher_req;
  logic            hold_ok;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick;
  logic            arb_now;
  logic            release_now;

`ifdef PIEZO_SCHED_TIMEOUT_EN
  logic [NREQ-1:0] lockout_q, lockout_d;
  logic [NREQ-1:0] arb_mask;
`endif

  always_comb begin
    owner_idx  = 2'd0;
    owner_tone = 8'h00;
    higher_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = 2'(i);
        owner_tone = bus.req_tone[8*i +: 8];
        for (int j = i + 1; j < NREQ; j++) begin
          if (bus.req[j]) higher_req = 1'b1;
        end
      end
    end
  end

  assign owner_req = |(bus.req & grant_q);
  assign hold_ok   = ({1'b0, hold_cnt_q} + 17'd1) >= 17'(MIN_HOLD);

  // Highest-index candidate wins; result is one-hot or zero by construction.
  always_comb begin
    pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    tone_d      = 8'h00;
    preempted_d = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    arb_now     = 1'b0;
    release_now = 1'b0;
`ifdef PIEZO_SCHED_TIMEOUT_EN
    // A lockout bit clears once its requester is seen low.
    lockout_d = lockout_q & bus.req;
    arb_mask  = '1;
`endif

    unique case (state_q)
      StIdle: arb_now = 1'b1;
      StGrant: begin
        hold_cnt_d = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
        tone_d     = bus.mute ? 8'h00 : owner_tone;
        if (!owner_req) begin
          release_now = 1'b1;
`ifdef PIEZO_SCHED_TIMEOUT_EN
        end else if (hold_cnt_q == 16'(MAX_GRANT - 1)) begin
          release_now = 1'b1;
          lockout_d   = lockout_d | grant_q;
          arb_mask    = ~grant_q;
`endif
        end else if (higher_req && hold_ok) begin
          release_now = 1'b1;
          preempted_d = 1'b1;
        end
        if (release_now) begin
          grant_d   = '0;
          tone_d    = 8'h00;
          gap_cnt_d = 16'd0;
          if (GAP == 0) arb_now = 1'b1;
          else          state_d = StGap;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (({1'b0, gap_cnt_q} + 17'd1) == 17'(GAP)) arb_now = 1'b1;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

`ifdef PIEZO_SCHED_TIMEOUT_EN
    cand = bus.req & ~lockout_q & arb_mask;
`else
    cand = bus.req;
`endif

    if (arb_now) begin
      tone_d     = 8'h00;
      hold_cnt_d = 16'd0;
      gap_cnt_d  = 16'd0;
      grant_d    = pick;
      state_d    = (|cand) ? StGrant : StIdle;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      tone_q      <= 8'h00;
      preempted_q <= 1'b0;
      hold_cnt_q  <= 16'd0;
      gap_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      tone_q      <= tone_d;
      preempted_q <= preempted_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef PIEZO_SCHED_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lockout_q <= '0;
    else        lockout_q <= lockout_d;
  end
`endif

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_idx;
  assign bus.busy      = (state_q != StIdle);
  assign bus.tone_out  = tone_q;
  assign bus.preempted = preempted_q;

endmodule

// File: tb/tb_piezo_scheduler.sv
// Directed bench for piezo_scheduler (NREQ=3, MIN_HOLD=50, GAP=10, MAX_GRANT=100).
module tb_piezo_scheduler;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  piezo_scheduler_if #(.NREQ(3)) bus ();

  piezo_scheduler #(
    .NREQ     (3),
    .MIN_HOLD (50),
    .GAP      (10),
    .MAX_GRANT(100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic to_idle();
    bus.req = 3'b000;
    tick(12);
    check("idle_busy", 16'(bus.busy), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.req = 3'b111;
    bus.req_tone = 24'h0;
    bus.mute = 1'b0;

    // Reset held with all requests pending.
    tick(5);
    check("rst_grant", 16'(bus.grant), 16'd0);
    check("rst_owner", 16'(bus.owner), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_tone", 16'(bus.tone_out), 16'd0);
    check("rst_pre", 16'(bus.preempted), 16'd0);
    reset = 1'b1;
    tick(1);
    check("rel_grant", 16'(bus.grant), 16'b100);
    check("rel_owner", 16'(bus.owner), 16'd2);
    check("rel_busy", 16'(bus.busy), 16'd1);
    to_idle();

    // Single owner with tone 04.
    bus.req = 3'b001;
    bus.req_tone = 24'h000004;
    tick(1);
    check("so_grant", 16'(bus.grant), 16'b001);
    check("so_tone0", 16'(bus.tone_out), 16'h00);
    tick(1);
    check("so_tone1", 16'(bus.tone_out), 16'h04);
    tick(17);
    check("so_hold", 16'(bus.grant), 16'b001);
    check("so_tone_end", 16'(bus.tone_out), 16'h04);
    bus.req = 3'b000;
    tick(1);
    check("so_drop_grant", 16'(bus.grant), 16'd0);
    check("so_drop_tone", 16'(bus.tone_out), 16'h00);
    check("so_gap_busy", 16'(bus.busy), 16'd1);
    tick(9);
    check("so_gap_last", 16'(bus.busy), 16'd1);
    tick(1);
    check("so_idle", 16'(bus.busy), 16'd0);

    // Preempt timing: owner 0 at t0, req[2] at t0+10.
    bus.req = 3'b001;
    tick(1);
    check("pe_t0", 16'(bus.grant), 16'b001);
    tick(10);
    bus.req = 3'b101;
    tick(39);
    check("pe_t49_grant", 16'(bus.grant), 16'b001);
    check("pe_t49_pre", 16'(bus.preempted), 16'd0);
    tick(1);
    check("pe_t50_pre", 16'(bus.preempted), 16'd1);
    check("pe_t50_grant", 16'(bus.grant), 16'd0);
    tick(1);
    check("pe_t51_pre", 16'(bus.preempted), 16'd0);
    tick(8);
    check("pe_t59_grant", 16'(bus.grant), 16'd0);
    tick(1);
    check("pe_t60_grant", 16'(bus.grant), 16'b100);
    check("pe_t60_owner", 16'(bus.owner), 16'd2);

    // Lower-priority request waits behind owner 2.
    tick(60);
    check("lp_hold", 16'(bus.grant), 16'b100);
    bus.req = 3'b001;
    tick(1);
    check("lp_drop", 16'(bus.grant), 16'd0);
    check("lp_drop_pre", 16'(bus.preempted), 16'd0);
    tick(9);
    check("lp_gap_last", 16'(bus.grant), 16'd0);
    tick(1);
    check("lp_regrant", 16'(bus.grant), 16'b001);
    check("lp_owner", 16'(bus.owner), 16'd0);
    to_idle();

    // Mute on owner 1, then confirm hold_cnt kept counting through it.
    bus.req = 3'b010;
    bus.req_tone = 24'h008000;
    tick(1);
    check("mu_grant", 16'(bus.grant), 16'b010);
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      check($sformatf("mu_tone_%0d", k), 16'(bus.tone_out),
            (k >= 6 && k <= 10) ? 16'h00 : 16'h80);
      bus.mute = (k >= 5 && k <= 9);
    end
    check("mu_grant_kept", 16'(bus.grant), 16'b010);
    bus.req = 3'b110;
    tick(35);
    check("mu_t49_grant", 16'(bus.grant), 16'b010);
    tick(1);
    check("mu_t50_pre", 16'(bus.preempted), 16'd1);
    to_idle();

    // Owner drop coinciding with higher request is a plain release.
    bus.req = 3'b001;
    tick(56);
    bus.req = 3'b100;
    tick(1);
    check("sd_pre", 16'(bus.preempted), 16'd0);
    check("sd_grant", 16'(bus.grant), 16'd0);
    to_idle();

`ifdef PIEZO_SCHED_TIMEOUT_EN
    // Grant limit and lockout.
    bus.req = 3'b001;
    tick(1);
    check("to_t0", 16'(bus.grant), 16'b001);
    tick(99);
    check("to_t99", 16'(bus.grant), 16'b001);
    tick(1);
    check("to_t100", 16'(bus.grant), 16'd0);
    check("to_pre", 16'(bus.preempted), 16'd0);
    tick(50);
    check("to_locked", 16'(bus.grant), 16'd0);
    check("to_locked_busy", 16'(bus.busy), 16'd0);
    bus.req = 3'b000;
    tick(1);
    bus.req = 3'b001;
    tick(1);
    check("to_regrant", 16'(bus.grant), 16'b001);
    to_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
